// File: rtl/ecc_point_add_if.sv
// Point-adder bundle: operand request, divider side-channel and result.
// slave = adder side, master = controller / divider side.
interface ecc_point_add_if #(
    parameter int MAX_BITS = 8
);
    logic                i_start;
    logic [MAX_BITS-1:0] i_n;
    logic [MAX_BITS-1:0] i_coef_a;
    logic [MAX_BITS-1:0] i_x1;
    logic [MAX_BITS-1:0] i_y1;
    logic [MAX_BITS-1:0] i_x2;
    logic [MAX_BITS-1:0] i_y2;
    logic                o_div_start;
    logic [MAX_BITS-1:0] o_div_a;
    logic [MAX_BITS-1:0] o_div_b;
    logic [MAX_BITS-1:0] i_div_result;
    logic                i_div_finished;
    logic [MAX_BITS-1:0] o_x3;
    logic [MAX_BITS-1:0] o_y3;
    logic                o_inf;
    logic                o_error;
    logic                o_finished;

    modport slave (
        input  i_start, i_n, i_coef_a,
        input  i_x1, i_y1, i_x2, i_y2,
        input  i_div_result, i_div_finished,
        output o_div_start, o_div_a, o_div_b,
        output o_x3, o_y3, o_inf, o_error, o_finished
    );

    modport master (
        output i_start, i_n, i_coef_a,
        output i_x1, i_y1, i_x2, i_y2,
        output i_div_result, i_div_finished,
        input  o_div_start, o_div_a, o_div_b,
        input  o_x3, o_y3, o_inf, o_error, o_finished
    );
endinterface

// File: rtl/ecc_point_add.sv
// Affine EC point adder over GF(n): P3 = P1 + P2, lambda via external
// divider, remaining products on an internal bit-serial modular multiplier.
// Ports: i_clk, i_rst (async, active-low), bus (ecc_point_add_if.slave):
//   i_start/i_n/i_coef_a/i_x1..i_y2 in, o_div_* / i_div_* divider link,
//   o_x3/o_y3/o_inf/o_error results, o_finished one-cycle done pulse.
// Option: define ECC_POINT_DOUBLE_EN to build the doubling path
// (otherwise P1 == P2, y1 != 0 ends with o_error).
module ecc_point_add #(
    parameter int MAX_BITS = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ecc_point_add_if.slave     bus
);
    localparam int W  = MAX_BITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef logic [W-1:0] word_t;
    typedef logic [W:0]   wide_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREP,
`ifdef ECC_POINT_DOUBLE_EN
        S_DBL_SQ,
        S_DBL_SUM,
`endif
        S_DIV_GO,
        S_DIV_WAIT,
        S_MUL_L2,
        S_SUB_X,
        S_MUL_Y,
        S_SUB_Y,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    word_t x1_q, y1_q, x2_q, y2_q;
    word_t num_q, den_q, lam_q;
    word_t x3_q, y3_q;
    logic  inf_q, err_q, fin_q;

    wide_t         mul_acc;
    logic [CW-1:0] mul_cnt;

    function automatic word_t mod_add(word_t a, word_t b, word_t n);
        wide_t s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n})
            s = s - {1'b0, n};
        return word_t'(s);
    endfunction

    function automatic word_t mod_sub(word_t a, word_t b, word_t n);
        wide_t d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, a} + {1'b0, n} - {1'b0, b};
        return word_t'(d);
    endfunction

    // Multiplier datapath: one MSB-first step of the interleaved product.
    wide_t         nw;
    word_t         mul_a, mul_b, t_val;
    logic [CW-1:0] bit_idx;
    logic          mul_bit, mul_last;
    wide_t         acc_dbl, acc_red, acc_add, acc_nxt;

    assign nw       = {1'b0, bus.i_n};
    assign t_val    = word_t'(mul_acc);
    assign mul_last = (mul_cnt == CW'(W - 1));
    assign bit_idx  = CW'(W - 1) - mul_cnt;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
`ifdef ECC_POINT_DOUBLE_EN
            S_DBL_SQ: begin
                mul_a = x1_q;
                mul_b = x1_q;
            end
`endif
            S_MUL_L2: begin
                mul_a = lam_q;
                mul_b = lam_q;
            end
            S_MUL_Y: begin
                mul_a = lam_q;
                mul_b = mod_sub(x1_q, x3_q, bus.i_n);
            end
            default: ;
        endcase
    end

    always_comb begin
        mul_bit = mul_b[bit_idx];
        acc_dbl = mul_acc << 1;
        acc_red = (acc_dbl >= nw) ? acc_dbl - nw : acc_dbl;
        acc_add = acc_red + {1'b0, mul_a};
        if (acc_add >= nw)
            acc_add = acc_add - nw;
        acc_nxt = mul_bit ? acc_add : acc_red;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (bus.i_start)
                    state_nxt = S_PREP;
            S_PREP:
                if (x1_q != x2_q)
                    state_nxt = S_DIV_GO;
                else if (y1_q != y2_q || y1_q == '0)
                    state_nxt = S_DONE;
                else
`ifdef ECC_POINT_DOUBLE_EN
                    state_nxt = S_DBL_SQ;
`else
                    state_nxt = S_DONE;
`endif
`ifdef ECC_POINT_DOUBLE_EN
            S_DBL_SQ:
                if (mul_last)
                    state_nxt = S_DBL_SUM;
            S_DBL_SUM:
                state_nxt = S_DIV_GO;
`endif
            S_DIV_GO:
                state_nxt = S_DIV_WAIT;
            S_DIV_WAIT:
                if (bus.i_div_finished)
                    state_nxt = S_MUL_L2;
            S_MUL_L2:
                if (mul_last)
                    state_nxt = S_SUB_X;
            S_SUB_X:
                state_nxt = S_MUL_Y;
            S_MUL_Y:
                if (mul_last)
                    state_nxt = S_SUB_Y;
            // The arithmetic path raises the done pulse straight from
            // SUB_Y so it lands one cycle after the last subtraction.
            S_SUB_Y:
                state_nxt = S_IDLE;
            S_DONE:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.o_div_start = (state == S_DIV_GO);
        bus.o_div_a     = num_q;
        bus.o_div_b     = den_q;
        bus.o_x3        = x3_q;
        bus.o_y3        = y3_q;
        bus.o_inf       = inf_q;
        bus.o_error     = err_q;
        bus.o_finished  = fin_q;
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            num_q   <= '0;
            den_q   <= '0;
            lam_q   <= '0;
            x3_q    <= '0;
            y3_q    <= '0;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    fin_q <= 1'b0;
                    if (bus.i_start) begin
                        x1_q  <= bus.i_x1;
                        y1_q  <= bus.i_y1;
                        x2_q  <= bus.i_x2;
                        y2_q  <= bus.i_y2;
                        x3_q  <= '0;
                        y3_q  <= '0;
                        inf_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (x1_q != x2_q) begin
                        num_q <= mod_sub(y2_q, y1_q, bus.i_n);
                        den_q <= mod_sub(x2_q, x1_q, bus.i_n);
                    end else if (y1_q != y2_q || y1_q == '0) begin
                        inf_q <= 1'b1;
                    end else begin
`ifdef ECC_POINT_DOUBLE_EN
                        mul_acc <= '0;
                        mul_cnt <= '0;
`else
                        err_q <= 1'b1;
`endif
                    end
                end
`ifdef ECC_POINT_DOUBLE_EN
                S_DBL_SQ: begin
                    mul_acc <= acc_nxt;
                    mul_cnt <= mul_last ? '0 : mul_cnt + 1'b1;
                end
                S_DBL_SUM: begin
                    num_q <= mod_add(
                        mod_add(mod_add(t_val, t_val, bus.i_n),
                                t_val, bus.i_n),
                        bus.i_coef_a, bus.i_n);
                    den_q <= mod_add(y1_q, y1_q, bus.i_n);
                end
`endif
                S_DIV_WAIT: begin
                    if (bus.i_div_finished) begin
                        lam_q   <= bus.i_div_result;
                        mul_acc <= '0;
                        mul_cnt <= '0;
                    end
                end
                S_MUL_L2, S_MUL_Y: begin
                    mul_acc <= acc_nxt;
                    mul_cnt <= mul_last ? '0 : mul_cnt + 1'b1;
                end
                S_SUB_X: begin
                    x3_q <= mod_sub(mod_sub(t_val, x1_q, bus.i_n),
                                    x2_q, bus.i_n);
                    mul_acc <= '0;
                    mul_cnt <= '0;
                end
                S_SUB_Y: begin
                    y3_q  <= mod_sub(t_val, y1_q, bus.i_n);
                    fin_q <= 1'b1;
                end
                S_DONE: begin
                    fin_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_point_add.sv
// Scoreboard bench for ecc_point_add, n = 17, a = 2, behavioural divider.
// Build with or without ECC_POINT_DOUBLE_EN.
`timescale 1ns/1ps
module tb_ecc_point_add;
    localparam int MB      = 8;
    localparam int N       = 17;
    localparam int A       = 2;
    localparam int DIV_LAT = 6;

    typedef struct packed {
        logic [MB-1:0] x3;
        logic [MB-1:0] y3;
        logic          inf;
        logic          err;
        logic          via_div;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ecc_point_add_if #(.MAX_BITS(MB)) bus ();

    ecc_point_add #(.MAX_BITS(MB)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   cyc      = 0;
    int   start_cyc;
    int   k_cyc    = -1;
    int   div_starts;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_div(int a, int b);
        for (int q = 0; q < N; q++)
            if ((q * b) % N == a % N)
                return q;
        return 0;
    endfunction

    function automatic exp_t model(int x1, int y1, int x2, int y2);
        exp_t e;
        int   num, den, lam, x3, y3;
        e = '0;
        if (x1 != x2) begin
            num = (y2 - y1 + N) % N;
            den = (x2 - x1 + N) % N;
        end else if (y1 != y2 || y1 == 0) begin
            e.inf = 1'b1;
            return e;
        end else begin
`ifdef ECC_POINT_DOUBLE_EN
            num = (3 * x1 * x1 + A) % N;
            den = (2 * y1) % N;
`else
            e.err = 1'b1;
            return e;
`endif
        end
        e.via_div = 1'b1;
        lam  = ref_div(num, den);
        x3   = (lam * lam + 2 * N - x1 - x2) % N;
        y3   = (lam * ((x1 - x3 + N) % N) + N - y1) % N;
        e.x3 = MB'(x3);
        e.y3 = MB'(y3);
        return e;
    endfunction

    // Behavioural divider: a / b mod n after DIV_LAT cycles.
    int            dv_cnt;
    logic [MB-1:0] dv_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_cnt             <= 0;
            dv_q               <= '0;
            bus.i_div_finished <= 1'b0;
            bus.i_div_result   <= '0;
        end else begin
            bus.i_div_finished <= 1'b0;
            if (bus.o_div_start) begin
                dv_cnt <= DIV_LAT;
                dv_q   <= MB'(ref_div(int'(bus.o_div_a),
                                      int'(bus.o_div_b)));
            end else if (dv_cnt > 0) begin
                dv_cnt <= dv_cnt - 1;
                if (dv_cnt == 1) begin
                    bus.i_div_finished <= 1'b1;
                    bus.i_div_result   <= dv_q;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.o_div_start)
                div_starts++;
            if (bus.i_div_finished)
                k_cyc = cyc;
            if (bus.o_finished) begin
                done_cnt++;
                chk("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("x3", bus.o_x3, e.x3);
                    chk("y3", bus.o_y3, e.y3);
                    chk("inf", bus.o_inf, e.inf);
                    chk("err", bus.o_error, e.err);
                    if (e.via_div) begin
                        chk("lat_div", cyc - k_cyc, 2 * MB + 3);
                    end else begin
                        chk("lat_short", cyc - start_cyc, 3);
                        chk("no_div", div_starts, 0);
                    end
                end
            end
        end
    end

    task automatic start_op(int x1, int y1, int x2, int y2);
        @(negedge clk);
        bus.i_x1    = MB'(x1);
        bus.i_y1    = MB'(y1);
        bus.i_x2    = MB'(x2);
        bus.i_y2    = MB'(y2);
        bus.i_start = 1'b1;
        start_cyc   = cyc;
        div_starts  = 0;
        k_cyc       = -1;
        sb.push_back(model(x1, y1, x2, y2));
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(int want, int budget);
        int t = 0;
        while (done_cnt < want && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(done_cnt >= want), 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int t;
        bus.i_start  = 1'b0;
        bus.i_n      = MB'(N);
        bus.i_coef_a = MB'(A);
        bus.i_x1     = '0;
        bus.i_y1     = '0;
        bus.i_x2     = '0;
        bus.i_y2     = '0;

        repeat (3) @(negedge clk);
        chk("rst_fin", bus.o_finished, 0);
        chk("rst_dstart", bus.o_div_start, 0);
        chk("rst_x3", bus.o_x3, 0);
        chk("rst_inf", bus.o_inf, 0);
        rst_n = 1'b1;

        // Plain addition
        start_op(5, 1, 6, 3);
        wait_done(1, 200);
        chk("add_x3", bus.o_x3, 10);
        chk("add_y3", bus.o_y3, 6);
        chk("add_num", bus.o_div_a, 2);
        chk("add_den", bus.o_div_b, 1);

        // Doubling (or error without the doubling path)
        start_op(5, 1, 5, 1);
        wait_done(2, 200);
`ifdef ECC_POINT_DOUBLE_EN
        chk("dbl_x3", bus.o_x3, 6);
        chk("dbl_y3", bus.o_y3, 3);
        chk("dbl_num", bus.o_div_a, 9);
        chk("dbl_den", bus.o_div_b, 2);
`else
        chk("dbl_err", bus.o_error, 1);
        chk("dbl_x3", bus.o_x3, 0);
`endif

        // Inverse points
        start_op(5, 1, 5, 16);
        wait_done(3, 200);
        chk("inv_inf", bus.o_inf, 1);
        chk("inv_err", bus.o_error, 0);

        // Mod wrap, with stray start pulses while busy
        start_op(10, 6, 6, 3);
        base = done_cnt;
        repeat (3) @(negedge clk);
        bus.i_x1    = 8'd1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (15) @(negedge clk);
        bus.i_x2    = 8'd2;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(4, 200);
        chk("wrap_x3", bus.o_x3, 9);
        chk("wrap_y3", bus.o_y3, 16);
        repeat (30) @(negedge clk);
        chk("busy_ignored", done_cnt - base, 1);
        chk("sb_drained", sb.size(), 0);

        // Reset during MUL_Y
        start_op(5, 1, 6, 3);
        t = 0;
        while (k_cyc < 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("div_timeout", 32'(k_cyc >= 0), 1);
        repeat (MB + 4) @(negedge clk);
        chk("pre_rst_x3", bus.o_x3, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_x3", bus.o_x3, 0);
        chk("mid_rst_divb", bus.o_div_b, 0);
        chk("mid_rst_diva", bus.o_div_a, 0);
        chk("mid_rst_fin", bus.o_finished, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        start_op(5, 1, 6, 3);
        wait_done(done_cnt + 1, 200);
        chk("post_x3", bus.o_x3, 10);
        chk("post_y3", bus.o_y3, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
